// File: rtl/pipe_pkg.sv
// Shared types and helpers for the handshaked pipeline-stage register.
package pipe_pkg;

   // Occupancy of the two-entry (skid) variant: number of held entries.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } pipe_state_t;

   // The skid variant accepts a new entry in every state except FULL.
   function automatic logic can_accept(input pipe_state_t st);
      return (st != FULL);
   endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid flag plus ctrl/data/dst payload.
// Clear beats load beats drop; payload only changes on load or reset.
module pipe_slot
   import pipe_pkg::*;
#(
   parameter int CTRL_W = 3,
   parameter int DATA_W = 64,
   parameter int DST_W  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              load,
   input  logic              drop,
   input  logic [CTRL_W-1:0] ld_ctrl,
   input  logic [DATA_W-1:0] ld_data,
   input  logic [DST_W-1:0]  ld_dst,
   output logic              valid,
   output logic [CTRL_W-1:0] ctrl,
   output logic [DATA_W-1:0] data,
   output logic [DST_W-1:0]  dst
);

   logic              valid_d, valid_q;
   logic [CTRL_W-1:0] ctrl_d,  ctrl_q;
   logic [DATA_W-1:0] data_d,  data_q;
   logic [DST_W-1:0]  dst_d,   dst_q;

   // Next entry contents from the clear/load/drop controls
   always_comb begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
      data_d  = data_q;
      dst_d   = dst_q;
      if (clr) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d = 1'b1;
         ctrl_d  = ld_ctrl;
         data_d  = ld_data;
         dst_d   = ld_dst;
      end else if (drop) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // Entry registers, synchronously reset to an empty all-zero entry
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         ctrl_q  <= {CTRL_W{1'b0}};
         data_q  <= {DATA_W{1'b0}};
         dst_q   <= {DST_W{1'b0}};
      end else begin
         valid_q <= valid_d;
         ctrl_q  <= ctrl_d;
         data_q  <= data_d;
         dst_q   <= dst_d;
      end
   end

   assign valid = valid_q;
   assign ctrl  = ctrl_q;
   assign data  = data_q;
   assign dst   = dst_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline-stage register with flush, bubble control squashing,
// optional two-entry skid buffer (registered in_ready) and a saturating
// stall counter.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int CTRL_W = 3,
   parameter int DATA_W = 64,
   parameter int DST_W  = 5,
   parameter int SKID   = 0,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   input  logic [DST_W-1:0]  in_dst,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [DST_W-1:0]  out_dst,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic              main_valid_s;
   logic [CTRL_W-1:0] main_ctrl_s;
   logic [DATA_W-1:0] main_data_s;
   logic [DST_W-1:0]  main_dst_s;
   logic              main_load_s;
   logic              main_drop_s;
   logic [CTRL_W-1:0] main_ld_ctrl_s;
   logic [DATA_W-1:0] main_ld_data_s;
   logic [DST_W-1:0]  main_ld_dst_s;
   logic              in_xfer_s;
   logic              out_xfer_s;
   logic [CNT_W-1:0]  stall_cnt_d, stall_cnt_q;

   assign in_xfer_s  = in_valid & in_ready;
   assign out_xfer_s = main_valid_s & out_ready;

   // The main slot is the one presented downstream.
   pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .DST_W(DST_W)) u_main (
      .clk     (clk),
      .rst     (rst),
      .clr     (flush),
      .load    (main_load_s),
      .drop    (main_drop_s),
      .ld_ctrl (main_ld_ctrl_s),
      .ld_data (main_ld_data_s),
      .ld_dst  (main_ld_dst_s),
      .valid   (main_valid_s),
      .ctrl    (main_ctrl_s),
      .data    (main_data_s),
      .dst     (main_dst_s)
   );

   generate
      if (SKID == 0) begin : g_single
         // Ready whenever the held entry (if any) leaves this cycle.
         assign in_ready = ~main_valid_s | out_ready;

         // Single entry: load on input transfer, empty on lone output transfer
         always_comb begin
            main_load_s    = in_xfer_s & ~flush;
            main_drop_s    = out_xfer_s & ~in_xfer_s;
            main_ld_ctrl_s = in_ctrl;
            main_ld_data_s = in_data;
            main_ld_dst_s  = in_dst;
         end
      end else begin : g_skid
         pipe_state_t       state_d, state_q;
         logic              in_ready_d, in_ready_q;
         logic              skid_load_s, skid_drop_s, take_skid_s;
         logic              skid_valid_s;
         logic [CTRL_W-1:0] skid_ctrl_s;
         logic [DATA_W-1:0] skid_data_s;
         logic [DST_W-1:0]  skid_dst_s;

         // Second slot catches the entry accepted while main is stalled.
         pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .DST_W(DST_W)) u_skid (
            .clk     (clk),
            .rst     (rst),
            .clr     (flush),
            .load    (skid_load_s),
            .drop    (skid_drop_s),
            .ld_ctrl (in_ctrl),
            .ld_data (in_data),
            .ld_dst  (in_dst),
            .valid   (skid_valid_s),
            .ctrl    (skid_ctrl_s),
            .data    (skid_data_s),
            .dst     (skid_dst_s)
         );

         // Occupancy FSM next state and slot load/drop steering
         always_comb begin
            state_d     = state_q;
            main_load_s = 1'b0;
            main_drop_s = 1'b0;
            skid_load_s = 1'b0;
            skid_drop_s = 1'b0;
            take_skid_s = 1'b0;
            if (flush) begin
               state_d = EMPTY;
            end else begin
               case (state_q)
                  EMPTY: begin
                     if (in_xfer_s) begin
                        main_load_s = 1'b1;
                        state_d     = ONE;
                     end else begin
                        state_d = EMPTY;
                     end
                  end
                  ONE: begin
                     if (in_xfer_s && out_xfer_s) begin
                        main_load_s = 1'b1;
                        state_d     = ONE;
                     end else if (in_xfer_s) begin
                        skid_load_s = 1'b1;
                        state_d     = FULL;
                     end else if (out_xfer_s) begin
                        main_drop_s = 1'b1;
                        state_d     = EMPTY;
                     end else begin
                        state_d = ONE;
                     end
                  end
                  FULL: begin
                     if (out_xfer_s && skid_valid_s) begin
                        main_load_s = 1'b1;
                        take_skid_s = 1'b1;
                        skid_drop_s = 1'b1;
                        state_d     = ONE;
                     end else begin
                        state_d = FULL;
                     end
                  end
                  default: begin
                     state_d = EMPTY;
                  end
               endcase
            end
            in_ready_d = can_accept(state_d);
         end

         // Main slot refills from skid when draining FULL, else from input
         always_comb begin
            main_ld_ctrl_s = take_skid_s ? skid_ctrl_s : in_ctrl;
            main_ld_data_s = take_skid_s ? skid_data_s : in_data;
            main_ld_dst_s  = take_skid_s ? skid_dst_s  : in_dst;
         end

         // Occupancy state and registered in_ready (low during reset)
         always_ff @(posedge clk) begin
            if (rst) begin
               state_q    <= EMPTY;
               in_ready_q <= 1'b0;
            end else begin
               state_q    <= state_d;
               in_ready_q <= in_ready_d;
            end
         end

         assign in_ready = in_ready_q;
      end
   endgenerate

   // Count stalled cycles, holding at the all-ones maximum
   always_comb begin
      if (main_valid_s & ~out_ready & (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1'b1);
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // Stall counter register; only reset clears it
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= {CNT_W{1'b0}};
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign out_valid = main_valid_s;
   assign out_ctrl  = main_ctrl_s & {CTRL_W{main_valid_s}};
   assign out_data  = main_data_s;
   assign out_dst   = main_dst_s;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: two instances (single-entry and skid) share stimulus.
// Accepted entries are queued per instance; a negedge monitor pops and
// compares whenever an entry leaves, and checks handshake and counter.
module tb_pipe_stage_reg;

   typedef struct packed {
      logic [2:0]  c;
      logic [63:0] d;
      logic [4:0]  t;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic [2:0]  in_ctrl;
   logic [63:0] in_data;
   logic [4:0]  in_dst;

   logic [1:0]  in_ready_w;
   logic [1:0]  out_valid_w;
   logic [2:0]  out_ctrl_w [2];
   logic [63:0] out_data_w [2];
   logic [4:0]  out_dst_w  [2];
   logic [15:0] sc0;
   logic [3:0]  sc1;

   ent_t        q0[$];
   ent_t        q1[$];
   logic [1:0]  exp_ov, exp_ir;
   logic        last_rst = 1'b1;
   logic        rst_prev = 1'b0;
   logic        started  = 1'b0;
   int unsigned scnt [2] = '{0, 0};
   int          checks   = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.SKID(0), .CNT_W(16)) u_d0 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_w[0]),
      .in_ctrl(in_ctrl), .in_data(in_data), .in_dst(in_dst), .out_valid(out_valid_w[0]),
      .out_ready(out_ready), .out_ctrl(out_ctrl_w[0]), .out_data(out_data_w[0]),
      .out_dst(out_dst_w[0]), .stall_cnt(sc0)
   );

   pipe_stage_reg #(.SKID(1), .CNT_W(4)) u_d1 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_w[1]),
      .in_ctrl(in_ctrl), .in_data(in_data), .in_dst(in_dst), .out_valid(out_valid_w[1]),
      .out_ready(out_ready), .out_ctrl(out_ctrl_w[1]), .out_data(out_data_w[1]),
      .out_dst(out_dst_w[1]), .stall_cnt(sc1)
   );

   task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s dut%0d act=%0h exp=%0h", nm, i, act, exp);
      end
   endtask

   function automatic int qsize(input int i);
      return (i == 0) ? q0.size() : q1.size();
   endfunction

   function automatic ent_t qfront(input int i);
      return (i == 0) ? q0[0] : q1[0];
   endfunction

   function automatic void qpop(input int i);
      if (i == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
   endfunction

   function automatic logic [63:0] sc_of(input int i);
      return (i == 0) ? {48'd0, sc0} : {60'd0, sc1};
   endfunction

   // One cycle of stimulus; expectations derive from entries held so far.
   task automatic step(input logic r, input logic f, input logic v, input logic rdy,
                       input logic [2:0] c, input logic [63:0] d, input logic [4:0] t);
      ent_t e;
      @(posedge clk);
      #1;
      rst = r; flush = f; in_valid = v; out_ready = rdy;
      in_ctrl = c; in_data = d; in_dst = t;
      #1;
      exp_ov[0] = (q0.size() > 0);
      exp_ov[1] = (q1.size() > 0);
      exp_ir[0] = (q0.size() == 0) | rdy;
      exp_ir[1] = ~last_rst & (q1.size() < 2);
      e = '{c: c, d: d, t: t};
      if (v && !f && !r) begin
         if (exp_ir[0]) q0.push_back(e);
         if (exp_ir[1]) q1.push_back(e);
      end
      last_rst = r;
   endtask

   // Monitor: compare presented outputs, then advance model state.
   always @(negedge clk) begin
      ent_t e;
      if (started) begin
         for (int i = 0; i < 2; i++) begin
            chk("out_valid", i, 64'(out_valid_w[i]), 64'(exp_ov[i]));
            chk("in_ready", i, 64'(in_ready_w[i]), 64'(exp_ir[i]));
            chk("stall_cnt", i, sc_of(i), 64'(scnt[i]));
            if (!out_valid_w[i]) chk("bubble_ctrl", i, 64'(out_ctrl_w[i]), 64'd0);
            if (rst_prev) begin
               chk("rst_data", i, out_data_w[i], 64'd0);
               chk("rst_dst", i, 64'(out_dst_w[i]), 64'd0);
            end
            if (out_valid_w[i] && qsize(i) > 0) begin
               e = qfront(i);
               chk("out_ctrl", i, 64'(out_ctrl_w[i]), 64'(e.c));
               chk("out_data", i, out_data_w[i], e.d);
               chk("out_dst", i, 64'(out_dst_w[i]), 64'(e.t));
            end
         end
      end
      for (int i = 0; i < 2; i++) begin
         if (exp_ov[i] && out_ready && qsize(i) > 0) qpop(i);
         if (rst) scnt[i] = 0;
         else if (exp_ov[i] && !out_ready && scnt[i] < ((i == 0) ? 32'd65535 : 32'd15)) scnt[i]++;
      end
      if (rst || flush) begin
         q0.delete();
         q1.delete();
      end
      rst_prev = rst;
      if (rst) started = 1'b1;
   end

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_ctrl = 3'd0; in_data = 64'd0; in_dst = 5'd0;
      exp_ov = 2'b00; exp_ir = 2'b00;
      step(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 64'd0, 5'd0);
      step(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 64'd0, 5'd0);

      // Stream 8 entries at full rate
      for (int k = 1; k <= 8; k++) step(1'b0, 1'b0, 1'b1, 1'b1, 3'b111, 64'(k), 5'(k));
      step(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 64'd0, 5'd0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 64'd0, 5'd0);
      chk("stream_stall", 0, {48'd0, sc0}, 64'd0);
      chk("stream_stall", 1, {60'd0, sc1}, 64'd0);

      // Back-pressure: skid instance takes A and B, then drops in_ready
      step(1'b0, 1'b0, 1'b1, 1'b0, 3'b101, 64'hA, 5'd10);
      step(1'b0, 1'b0, 1'b1, 1'b0, 3'b110, 64'hB, 5'd11);
      step(1'b0, 1'b0, 1'b1, 1'b0, 3'b011, 64'hC, 5'd12);
      chk("skid_full_ready", 1, 64'(in_ready_w[1]), 64'd0);
      for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 5'd0);
      chk("skid_hold_data", 1, out_data_w[1], 64'hA);
      for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 64'd0, 5'd0);

      // Flush a full stage while 0x5 is offered
      step(1'b0, 1'b0, 1'b1, 1'b0, 3'b111, 64'h21, 5'd2);
      step(1'b0, 1'b0, 1'b1, 1'b0, 3'b111, 64'h22, 5'd3);
      step(1'b0, 1'b1, 1'b1, 1'b0, 3'b111, 64'h5, 5'd4);
      step(1'b0, 1'b0, 1'b0, 1'b1, 3'b111, 64'd0, 5'd0);
      for (int i = 0; i < 2; i++) begin
         chk("flush_valid", i, 64'(out_valid_w[i]), 64'd0);
         chk("flush_ctrl", i, 64'(out_ctrl_w[i]), 64'd0);
      end

      // Bubbles with all control bits set upstream
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 1'b1, 3'b111, 64'hFF, 5'd31);
      for (int i = 0; i < 2; i++) chk("bubble_squash", i, 64'(out_ctrl_w[i]), 64'd0);

      // Long stall saturates the 4-bit counter
      step(1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 64'h77, 5'd5);
      for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 5'd0);
      chk("stall_sat", 1, {60'd0, sc1}, 64'd15);
      step(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 64'd0, 5'd0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 64'd0, 5'd0);

      // Reset in the middle of a stream
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, 1'b1, 3'b100, 64'(100 + k), 5'(k));
      step(1'b1, 1'b0, 1'b1, 1'b1, 3'b100, 64'h99, 5'd9);
      step(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 64'd0, 5'd0);
      for (int i = 0; i < 2; i++) begin
         chk("rst_mid_valid", i, 64'(out_valid_w[i]), 64'd0);
         chk("rst_mid_data", i, out_data_w[i], 64'd0);
         chk("rst_mid_cnt", i, sc_of(i), 64'd0);
      end
      step(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 64'd0, 5'd0);
      chk("rst_release_ready", 1, 64'(in_ready_w[1]), 64'd1);

      // Randomized traffic with occasional flush and reset
      for (int k = 0; k < 400; k++) begin
         step(($urandom_range(99) == 0), ($urandom_range(31) == 0), ($urandom_range(3) != 0),
              ($urandom_range(2) != 0), 3'($urandom_range(7)), {$urandom, $urandom},
              5'($urandom_range(31)));
      end
      for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 64'd0, 5'd0);
      @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, handshaked pipeline-stage register. It replaces the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block that has configurable payload widths and valid/ready back-pressure. It also adds synchronous flush, control-bit squashing on bubbles, an optional two-entry skid mode that registers `in_ready`, and a saturating stall counter. One instance sits between each pair of adjacent CPU stages.

## Interface
Parameters:
- `CTRL_W`, default 3: control-bit bundle width (e.g. memWr/regWr/Wrback).
- `DATA_W`, default 64: data payload width (e.g. ALU result concatenated with store data).
- `DST_W`, default 5: destination register index width.
- `SKID`, default 0: 0 = single entry, combinational `in_ready`; 1 = two entries, registered `in_ready`.
- `CNT_W`, default 16: stall counter width.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `flush`, input, 1: synchronous squash of all held and incoming entries.
- `in_valid`, input, 1: upstream entry valid.
- `in_ready`, output, 1: stage can accept an entry this cycle.
- `in_ctrl`, input, CTRL_W: upstream control bits.
- `in_data`, input, DATA_W: upstream data payload.
- `in_dst`, input, DST_W: upstream destination register index.
- `out_valid`, output, 1: downstream entry valid.
- `out_ready`, input, 1: downstream accepts this cycle.
- `out_ctrl`, output, CTRL_W: control bits; forced to 0 whenever `out_valid`=0.
- `out_data`, output, DATA_W: data payload.
- `out_dst`, output, DST_W: destination register index.
- `stall_cnt`, output, CNT_W: saturating count of cycles with `out_valid & ~out_ready`.

## Operation
- Transfer rules:
  - Input transfer: `in_valid & in_ready`.
  - Output transfer: `out_valid & out_ready`.
- Priority: `rst` > `flush` > normal operation.
- Reset (`rst`=1 at an edge):
  - All valid flags and the counter go to 0; payload registers go to 0.
  - `out_valid`=0, `out_ctrl`=0, `out_data`=0, `out_dst`=0, `stall_cnt`=0.
  - `in_ready`: for SKID=1 it is 0 while `rst` is high and 1 from the first cycle after release; for SKID=0 it follows its formula (1, since the stage is empty).
- Flush:
  - All valid flags clear at the next edge.
  - Any input presented in the same cycle is discarded, even if `in_ready`=1.
  - Payload registers need not clear.
- SKID=0:
  - `in_ready = ~out_valid | out_ready`.
  - The main register loads on an input transfer.
  - `out_valid` clears on an output transfer with no simultaneous input transfer.
- SKID=1 state machine (state = number of held entries):
  - EMPTY: on input transfer, load main and go to ONE.
  - ONE, input transfer with output transfer: main reloads; stay in ONE.
  - ONE, input transfer without output transfer: load skid; go to FULL.
  - ONE, output transfer only: go to EMPTY.
  - FULL, output transfer: skid moves to main; go to ONE.
  - `in_ready` is a registered output equal to 1 exactly when the state is not FULL.
  - In FULL no input is accepted; `in_ready`=0 guarantees this.
- Ordering: entries leave in acceptance order; none is duplicated or lost except by flush.
- Stall counter:
  - Increments by 1 on each cycle with `out_valid & ~out_ready`.
  - Holds at 2^CNT_W-1.
  - Cleared only by `rst`; flush does not clear it.

## Timing
- Latency: 1 cycle from input transfer to `out_valid`, in both modes.
- Throughput: 1 entry/cycle when `out_ready` stays high.
- Output stability: while `out_valid & ~out_ready`, all `out_*` hold stable.
- Combinational paths:
  - SKID=0: `out_ready` → `in_ready` is combinational.
  - SKID=1: no combinational input→output path; all outputs come from flops, except the `out_ctrl` AND gate with `out_valid`.
- Flush and output transfer in the same cycle: the output transfer counts downstream; the stage is empty on the next cycle.
- `rst` asserted mid-stream: the held entry is lost; `out_valid`=0 on the next cycle.

## Structure
- Shared package `pipe_pkg`: SKID state enum `pipe_state_t` {EMPTY, ONE, FULL}, 2 bits.
- Sub-module `pipe_slot`: one entry (valid, ctrl, data, dst) with load/clear controls. Instantiated once for SKID=0 and twice (main, skid) for SKID=1.
- The control FSM and stall counter live in the top module.

## Test plan
- Reset, then stream 8 entries (data = 1..8, ctrl=3'b111) with `out_ready`=1 → outputs appear 1 cycle later, in order, with `out_valid` high for 8 consecutive cycles; `stall_cnt`=0.
- SKID=1: hold `out_ready`=0 while driving 3 entries (0xA, 0xB, 0xC) → `in_ready` drops after 0xB is accepted; `out_data` holds 0xA; `stall_cnt` counts 1 per cycle. Release `out_ready` → 0xA then 0xB, with no loss or duplication.
- Flush with a full stage and `in_valid`=1 (data 0x5) → next cycle `out_valid`=0 and `out_ctrl`=0; 0x5 never appears.
- Bubble squash: `in_valid`=0 with `in_ctrl`=3'b111 → `out_ctrl` stays 3'b000.
- Counter saturation with CNT_W=4: hold a stall for 20 cycles → `stall_cnt` reaches 15 and holds.
- Assert `rst` mid-stream for 1 cycle → all outputs are 0 next cycle; SKID=1 `in_ready` returns to 1 the cycle after release.
